// File: rtl/uart_pkg.sv
// Shared definitions for the UART serial engine: FSM encodings and framing constants.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_baudgen.sv
// Free-running 16x oversampling tick generator; a divisor change applies at the next reload.
module uart_baudgen (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] divisor,
  output logic        en16
);

  logic [15:0] cnt;

  assign en16 = (cnt == 16'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= 16'd0;
    end else if (en16) begin
      cnt <= (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: rtl/uart_phy.sv
// 8N1 UART line engine: 16x oversampling receiver and transmitter sharing one tick generator.
module uart_phy
  import uart_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rxd,
  output logic        uart_txd,
  input  logic [15:0] divisor,
  output logic [7:0]  rx_data,
  output logic        rx_done,
  output logic        rx_frame_err,
  input  logic [7:0]  tx_data,
  input  logic        tx_wr,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam logic [3:0] SUB_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SUB_MID  = 4'(MID_SAMPLE);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  logic en16;

  uart_baudgen u_baudgen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .divisor (divisor),
    .en16    (en16)
  );

  // ---------------- receiver ----------------
  logic      rxd_meta, rxd_sync;
  rx_state_t rx_state, rx_state_d;
  logic [3:0] rcnt, rcnt_d;
  logic [2:0] ridx, ridx_d;
  logic [7:0] rshift, rshift_d, rx_data_d;
  logic       rx_done_d, rx_err_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rxd_meta     <= 1'b1;
      rxd_sync     <= 1'b1;
      rx_state     <= R_IDLE;
      rcnt         <= 4'd0;
      ridx         <= 3'd0;
      rshift       <= 8'd0;
      rx_data      <= 8'd0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rxd_meta     <= uart_rxd;
      rxd_sync     <= rxd_meta;
      rx_state     <= rx_state_d;
      rcnt         <= rcnt_d;
      ridx         <= ridx_d;
      rshift       <= rshift_d;
      rx_data      <= rx_data_d;
      rx_done      <= rx_done_d;
      rx_frame_err <= rx_err_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    rx_state_d = rx_state;
    rcnt_d     = rcnt;
    ridx_d     = ridx;
    rshift_d   = rshift;
    rx_data_d  = rx_data;
    rx_done_d  = 1'b0;
    rx_err_d   = 1'b0;
    if (en16) begin
      rcnt_d = rcnt + 4'd1;
      case (rx_state)
        R_IDLE: begin
          if (!rxd_sync) begin
            rcnt_d     = 4'd0;
            rx_state_d = R_START;
          end
        end
        R_START: begin
          if (rcnt == SUB_MID) begin
            if (!rxd_sync) begin
              rcnt_d     = 4'd0;
              ridx_d     = 3'd0;
              rx_state_d = R_DATA;
            end else begin
              rx_state_d = R_IDLE;
            end
          end
        end
        R_DATA: begin
          if (rcnt == SUB_LAST) begin
            rshift_d = {rxd_sync, rshift[7:1]};
            if (ridx == IDX_LAST) rx_state_d = R_STOP;
            else                  ridx_d     = ridx + 3'd1;
          end
        end
        R_STOP: begin
          // Returning to idle at mid-stop lets the next start edge be caught early.
          if (rcnt == SUB_LAST) begin
            if (rxd_sync) begin
              rx_data_d = rshift;
              rx_done_d = 1'b1;
            end else begin
              rx_err_d  = 1'b1;
            end
            rx_state_d = R_IDLE;
          end
        end
        default: rx_state_d = R_IDLE;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t tx_state, tx_state_d;
  logic [3:0] tcnt, tcnt_d;
  logic [2:0] tidx, tidx_d;
  logic [7:0] tshift, tshift_d;
  logic       txd_d, tx_busy_d, tx_done_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_state <= T_IDLE;
      tcnt     <= 4'd0;
      tidx     <= 3'd0;
      tshift   <= 8'd0;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      tcnt     <= tcnt_d;
      tidx     <= tidx_d;
      tshift   <= tshift_d;
      uart_txd <= txd_d;
      tx_busy  <= tx_busy_d;
      tx_done  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tcnt_d     = tcnt;
    tidx_d     = tidx;
    tshift_d   = tshift;
    txd_d      = uart_txd;
    tx_busy_d  = tx_busy;
    tx_done_d  = 1'b0;
    case (tx_state)
      T_IDLE: begin
        // Busy while idle means a byte is accepted and waits for the next tick.
        if (tx_busy) begin
          if (en16) begin
            txd_d      = 1'b0;
            tcnt_d     = 4'd0;
            tx_state_d = T_START;
          end
        end else if (tx_wr) begin
          tshift_d  = tx_data;
          tx_busy_d = 1'b1;
        end
      end
      T_START: begin
        if (en16) begin
          tcnt_d = tcnt + 4'd1;
          if (tcnt == SUB_LAST) begin
            txd_d      = tshift[0];
            tshift_d   = {1'b0, tshift[7:1]};
            tidx_d     = 3'd0;
            tx_state_d = T_DATA;
          end
        end
      end
      T_DATA: begin
        if (en16) begin
          tcnt_d = tcnt + 4'd1;
          if (tcnt == SUB_LAST) begin
            if (tidx == IDX_LAST) begin
              txd_d      = 1'b1;
              tx_state_d = T_STOP;
            end else begin
              tidx_d   = tidx + 3'd1;
              txd_d    = tshift[0];
              tshift_d = {1'b0, tshift[7:1]};
            end
          end
        end
      end
      T_STOP: begin
        if (en16) begin
          tcnt_d = tcnt + 4'd1;
          if (tcnt == SUB_LAST) begin
            tx_busy_d  = 1'b0;
            tx_done_d  = 1'b1;
            tx_state_d = T_IDLE;
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_phy.sv
// Directed bench for uart_phy: TX framing, RX framing/glitch, TX overlap, divisor 0/1 loopback, async reset.
module tb_uart_phy;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        uart_rxd;
  logic        uart_txd;
  logic [15:0] divisor;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        rx_frame_err;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        tx_done;

  logic rxd_drv  = 1'b1;
  logic loopback = 1'b0;
  assign uart_rxd = loopback ? uart_txd : rxd_drv;

  int checks   = 0;
  int failures = 0;

  int unsigned cyc         = 0;
  int unsigned tx_done_cnt = 0;
  int unsigned busy_cyc    = 0;
  int unsigned rx_done_cnt = 0;
  int unsigned rx_err_cnt  = 0;
  int unsigned both_cnt    = 0;
  int unsigned rx_done_at  = 0;

  logic [7:0] lb_bytes [3] = '{8'h00, 8'hFF, 8'h80};

  uart_phy dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .uart_rxd     (uart_rxd),
    .uart_txd     (uart_txd),
    .divisor      (divisor),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_frame_err (rx_frame_err),
    .tx_data      (tx_data),
    .tx_wr        (tx_wr),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (tx_done)              tx_done_cnt <= tx_done_cnt + 1;
    if (tx_busy)              busy_cyc    <= busy_cyc + 1;
    if (rx_done) begin
      rx_done_cnt <= rx_done_cnt + 1;
      rx_done_at  <= cyc;
    end
    if (rx_frame_err)         rx_err_cnt  <= rx_err_cnt + 1;
    if (rx_done && rx_frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_tx(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    tick(1);
    tx_wr   = 1'b0;
  endtask

  // Samples the TX line mid-bit, starting from the falling edge of the start bit.
  task automatic decode_tx(input string tag, input int cpb, output logic [7:0] d);
    int n = 0;
    d = 8'h00;
    while (uart_txd !== 1'b0 && n < 20 * cpb) begin
      tick(1);
      n++;
    end
    if (uart_txd !== 1'b0) begin
      check({tag, "_start_seen"}, uart_txd, 1'b0);
      return;
    end
    tick(cpb / 2);
    check({tag, "_start_bit"}, uart_txd, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(cpb);
      d[i] = uart_txd;
    end
    tick(cpb);
    check({tag, "_stop_bit"}, uart_txd, 1'b1);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input int cpb,
                         output int unsigned mid_stop);
    rxd_drv = 1'b0;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      tick(cpb);
    end
    rxd_drv = stop;
    tick(cpb / 2);
    mid_stop = cyc;
    if (stop) tick(cpb - cpb / 2);
    else      tick(100);
    rxd_drv = 1'b1;
  endtask

  task automatic wait_tx_done(input int unsigned snap, input int limit);
    int n = 0;
    while (tx_done_cnt == snap && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_rx_done(input int unsigned snap, input int limit);
    int n = 0;
    while (rx_done_cnt == snap && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  d;
    int unsigned mid, s_done, s_busy, s_rd, s_re, len;
    int          n;

    sys_rst = 1'b1;
    tx_wr   = 1'b0;
    tx_data = 8'h00;
    divisor = 16'd54;
    tick(3);
    check("rst_txd",      uart_txd,     1'b1);
    check("rst_rx_data",  rx_data,      8'h00);
    check("rst_rx_done",  rx_done,      1'b0);
    check("rst_rx_err",   rx_frame_err, 1'b0);
    check("rst_tx_busy",  tx_busy,      1'b0);
    check("rst_tx_done",  tx_done,      1'b0);
    sys_rst = 1'b0;
    tick(5);

    // TX 0xA5 at 864 cycles/bit: line 0,1,0,1,0,0,1,0,1,1
    s_done = tx_done_cnt;
    s_busy = busy_cyc;
    send_tx(8'hA5);
    decode_tx("tx_a5", 864, d);
    check("tx_a5_data", d, 8'hA5);
    wait_tx_done(s_done, 1000);
    tick(2);
    check("tx_a5_done_pulses", tx_done_cnt - s_done, 1);
    len = busy_cyc - s_busy;
    check("tx_a5_busy_len", (len >= 8640 && len <= 8700), 1'b1);
    check("tx_a5_idle_line", uart_txd, 1'b1);

    // RX 0x3C, good stop bit
    s_rd = rx_done_cnt;
    s_re = rx_err_cnt;
    send_rx(8'h3C, 1'b1, 864, mid);
    tick(5);
    check("rx_3c_data",    rx_data, 8'h3C);
    check("rx_3c_done",    rx_done_cnt - s_rd, 1);
    check("rx_3c_no_err",  rx_err_cnt - s_re, 0);
    check("rx_3c_latency", (rx_done_at >= mid && rx_done_at - mid <= 56), 1'b1);

    // RX 0x55 with low stop bit: frame error, data kept
    s_rd = rx_done_cnt;
    s_re = rx_err_cnt;
    send_rx(8'h55, 1'b0, 864, mid);
    tick(1500);
    check("rx_ferr_pulse",   rx_err_cnt - s_re, 1);
    check("rx_ferr_no_done", rx_done_cnt - s_rd, 0);
    check("rx_ferr_keep",    rx_data, 8'h3C);

    // 100-cycle glitch on idle line: no strobe, then a clean frame still decodes
    s_rd = rx_done_cnt;
    s_re = rx_err_cnt;
    rxd_drv = 1'b0;
    tick(100);
    rxd_drv = 1'b1;
    tick(1500);
    check("glitch_no_done", rx_done_cnt - s_rd, 0);
    check("glitch_no_err",  rx_err_cnt - s_re, 0);
    send_rx(8'h96, 1'b1, 864, mid);
    tick(5);
    check("glitch_after_data", rx_data, 8'h96);
    check("glitch_after_done", rx_done_cnt - s_rd, 1);

    // TX overlap at divisor 4: busy write ignored, write in tx_done cycle accepted
    divisor = 16'd4;
    tick(200);
    s_done = tx_done_cnt;
    send_tx(8'h11);
    tick(10);
    send_tx(8'h22);
    decode_tx("tx_ovl1", 64, d);
    check("tx_ovl1_data", d, 8'h11);
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check("tx_ovl_done_seen", tx_done, 1'b1);
    tx_data = 8'h33;
    tx_wr   = 1'b1;
    tick(1);
    tx_wr   = 1'b0;
    check("tx_b2b_accepted", tx_busy, 1'b1);
    decode_tx("tx_ovl2", 64, d);
    check("tx_ovl2_data", d, 8'h33);
    wait_tx_done(s_done + 1, 200);
    tick(2);
    check("tx_ovl_done_pulses", tx_done_cnt - s_done, 2);

    // divisor 0 and 1: 16 cycles/bit, looped back into the receiver
    loopback = 1'b1;
    for (int dv = 0; dv < 2; dv++) begin
      divisor = 16'(dv);
      tick(100);
      for (int b = 0; b < 3; b++) begin
        s_rd   = rx_done_cnt;
        s_done = tx_done_cnt;
        s_busy = busy_cyc;
        send_tx(lb_bytes[b]);
        decode_tx("lb_tx", 16, d);
        check("lb_tx_data", d, lb_bytes[b]);
        wait_rx_done(s_rd, 100);
        check("lb_rx_data", rx_data, lb_bytes[b]);
        wait_tx_done(s_done, 100);
        tick(2);
        len = busy_cyc - s_busy;
        check("lb_busy_len", (len >= 160 && len <= 163), 1'b1);
        tick(5);
      end
    end
    loopback = 1'b0;
    check("no_double_strobe", both_cnt, 0);

    // Async reset mid-TX: line high and strobes low without a clock edge
    divisor = 16'd54;
    tick(100);
    send_tx(8'h00);
    n = 0;
    while (uart_txd !== 1'b0 && n < 200) begin
      tick(1);
      n++;
    end
    tick(3000);
    check("rst_mid_pre_txd", uart_txd, 1'b0);
    #2;
    sys_rst = 1'b1;
    #1;
    check("rst_mid_txd",     uart_txd,     1'b1);
    check("rst_mid_busy",    tx_busy,      1'b0);
    check("rst_mid_strobes", {tx_done, rx_done, rx_frame_err}, 3'b000);
    check("rst_mid_rx_data", rx_data,      8'h00);
    tick(1);
    sys_rst = 1'b0;
    tick(20);
    check("rst_mid_after_txd",  uart_txd, 1'b1);
    check("rst_mid_after_busy", tx_busy,  1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
